rx_despreader: RTL and testbench

Receive-side data despreader for the 4-bit chip protocol used by the modem's frame generator. It sits downstream of the preamble correlator, which pulses `start` when the preamble ends. It takes 16-chip spread dibits, descrambles each chip against a locally regenerated scramble code, and majority-votes each dibit. It discards the extra slot inserted after every 8 data dibits, packs the dibits MSB-first into bytes, and writes the bytes to the message RAM.

---
 rtl/rx_despreader.sv | 198 +++++++++++++++++++
 tb/tb_rx_despreader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_despreader.sv
// rx_despreader: despreads 16-chip dibit slots against a locally supplied
// scramble code, majority-votes each dibit, drops the extra slot inserted
// after every 8 data dibits, packs dibits MSB-first into bytes and writes
// them to the message RAM.
module rx_despreader #(
    parameter int SPREAD = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    input  logic [15:0]       msg_length,
    input  logic              in_valid,
    input  logic [3:0]        in_data,
    input  logic [1:0]        scramble_code,
    output logic              scr_advance,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       chip_err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_EXTRA = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A dibit needs strictly more than half of the 16 chips to resolve to 1.
    localparam logic [4:0] VOTE_MIN = 5'd9;
    localparam logic [3:0] CHIP_LAST = 4'(SPREAD - 1);

    // Undo the scrambler mapping for one chip symbol.
    function automatic logic [1:0] descramble(input logic [1:0] code, input logic [1:0] s);
        case (code)
            2'b00:   return s;
            2'b01:   return {~s[0], s[1]};
            2'b10:   return {s[0], ~s[1]};
            default: return ~s;
        endcase
    endfunction

    // Drop dibit d into byte slot pos (0 = bits [7:6]); a new byte starts clean
    // so a partial last byte has its unfilled low bits at zero.
    function automatic logic [7:0] pack_dibit(input logic [7:0] cur, input logic [1:0] pos,
                                              input logic [1:0] d);
        logic [7:0] b;
        b = (pos == 2'd0) ? 8'h00 : cur;
        case (pos)
            2'd0:    b[7:6] = d;
            2'd1:    b[5:4] = d;
            2'd2:    b[3:2] = d;
            default: b[1:0] = d;
        endcase
        return b;
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_len;
    logic [15:0]         r_dibit_cnt;
    logic [3:0]          r_chip_cnt;
    logic [ADDR_W-1:0]   r_byte_idx;
    logic [15:0]         r_err_cnt;
    logic [4:0]          r_vote_hi;
    logic [4:0]          r_vote_lo;
    logic [7:0]          r_byte;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [7:0]          r_ram_wdata;

    logic                w_start_acc;
    logic                w_chip_acc;
    logic                w_chip_ok;
    logic [1:0]          w_dibit_chip;
    logic [4:0]          w_vote_hi_next;
    logic [4:0]          w_vote_lo_next;
    logic [1:0]          w_dibit_res;
    logic                w_slot_end;
    logic                w_data_slot_end;
    logic [15:0]         w_k_next;
    logic                w_last;
    logic                w_write;
    logic [7:0]          w_byte_next;

    assign w_start_acc    = (r_state == S_IDLE) && start && enable;
    assign w_chip_acc     = enable && in_valid && ((r_state == S_DATA) || (r_state == S_EXTRA));
    assign w_chip_ok      = in_data[2] & in_data[0];
    assign w_dibit_chip   = descramble(scramble_code, {in_data[3], in_data[1]});
    assign w_vote_hi_next = r_vote_hi + {4'd0, w_chip_ok & w_dibit_chip[1]};
    assign w_vote_lo_next = r_vote_lo + {4'd0, w_chip_ok & w_dibit_chip[0]};
    assign w_dibit_res    = {w_vote_hi_next >= VOTE_MIN, w_vote_lo_next >= VOTE_MIN};
    assign w_slot_end     = w_chip_acc && (r_chip_cnt == CHIP_LAST);
    assign w_data_slot_end = w_slot_end && (r_state == S_DATA);
    assign w_k_next       = r_dibit_cnt + 16'd1;
    assign w_last         = w_data_slot_end && (w_k_next == r_len);
    assign w_write        = w_data_slot_end && ((w_k_next[1:0] == 2'd0) || (w_k_next == r_len));
    assign w_byte_next    = pack_dibit(r_byte, r_dibit_cnt[1:0], w_dibit_res);

    assign scr_advance  = w_chip_acc;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
    assign chip_err_cnt = r_err_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode: frame start, slot completion, extra-slot insertion.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc)
                    w_state_next = (msg_length == 16'd0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                if (w_data_slot_end) begin
                    if (w_last)                     w_state_next = S_DONE;
                    else if (w_k_next[2:0] == 3'd0) w_state_next = S_EXTRA;
                end
            end
            S_EXTRA: begin
                if (w_slot_end) w_state_next = S_DATA;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Frame counters: chips in slot, dibits resolved, byte index, chip errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= 16'd0;
            r_dibit_cnt <= 16'd0;
            r_chip_cnt  <= 4'd0;
            r_byte_idx  <= '0;
            r_err_cnt   <= 16'd0;
        end else if (w_start_acc) begin
            r_len       <= msg_length;
            r_dibit_cnt <= 16'd0;
            r_chip_cnt  <= 4'd0;
            r_byte_idx  <= '0;
            r_err_cnt   <= 16'd0;
        end else if (w_chip_acc) begin
            r_chip_cnt <= r_chip_cnt + 4'd1;
            if (!w_chip_ok) r_err_cnt <= sat_inc16(r_err_cnt);
            if (w_data_slot_end) r_dibit_cnt <= w_k_next;
            if (w_write) r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

    // Vote accumulators and byte assembly; cleared at frame and slot start.
    always_ff @(posedge clk) begin
        if (w_start_acc) begin
            r_vote_hi <= 5'd0;
            r_vote_lo <= 5'd0;
        end else if (w_chip_acc) begin
            if (w_slot_end) begin
                r_vote_hi <= 5'd0;
                r_vote_lo <= 5'd0;
            end else begin
                r_vote_hi <= w_vote_hi_next;
                r_vote_lo <= w_vote_lo_next;
            end
            if (w_data_slot_end) r_byte <= w_byte_next;
        end
    end

    // Registered RAM write port; the strobe is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= 8'h00;
        end else begin
            r_ram_we <= w_write;
            if (w_write) begin
                r_ram_addr  <= r_byte_idx;
                r_ram_wdata <= w_byte_next;
            end
        end
    end

endmodule

// File: tb/tb_rx_despreader.sv
// Scoreboard bench for rx_despreader: frames are built as chip streams, a
// reference model decodes them into expected RAM writes, and a monitor checks
// every write / done pulse as the DUT produces it.
module tb_rx_despreader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset, enable, start, in_valid;
    logic [15:0]   msg_length;
    logic [3:0]    in_data;
    logic [1:0]    scramble_code;
    logic          scr_advance, ram_we, busy, done;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [15:0]   chip_err_cnt;

    always #5 clk = ~clk;

    rx_despreader #(.SPREAD(16), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .msg_length(msg_length), .in_valid(in_valid), .in_data(in_data),
        .scramble_code(scramble_code), .scr_advance(scr_advance),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .chip_err_cnt(chip_err_cnt)
    );

    typedef struct { int addr; int data; bit last; } wr_t;

    int       n_checks = 0;
    int       n_fail = 0;
    wr_t      exp_q[$];
    wr_t      mon_e;
    int       exp_solo_done = 0;
    int       adv_cnt = 0;
    bit [3:0] chip_q[$];
    bit [1:0] code_q[$];
    int       src_d[64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scramble mapping as tabulated: code selects how symbol s maps to dibit.
    function automatic int descr(input int code, input int s);
        case (code)
            0: return s;
            1: case (s) 0: return 2; 1: return 0; 2: return 3; default: return 1; endcase
            2: case (s) 0: return 1; 1: return 3; 2: return 0; default: return 2; endcase
            default: return 3 - s;
        endcase
    endfunction

    function automatic int enc(input int d, input int code);
        for (int s = 0; s < 4; s++) if (descr(code, s) == d) return s;
        return 0;
    endfunction

    function automatic bit [3:0] mkchip(input int s);
        bit [1:0] ss;
        ss = s[1:0];
        return {ss[1], 1'b1, ss[0], 1'b1};
    endfunction

    // One 16-chip slot: ninval invalid chips, nwrong chips voting for ~d, rest for d.
    task automatic add_slot(input int d, input int mode, input int nwrong, input int ninval);
        int code;
        for (int i = 0; i < 16; i++) begin
            code = (mode == 0) ? 0 : (mode == 1) ? (i % 4) : int'($urandom_range(3));
            if (i < ninval)               chip_q.push_back((i % 2 == 0) ? 4'b0000 : 4'b1010);
            else if (i < ninval + nwrong) chip_q.push_back(mkchip(enc(d ^ 3, code)));
            else                          chip_q.push_back(mkchip(enc(d, code)));
            code_q.push_back(code[1:0]);
        end
    endtask

    task automatic build(input int n, input int mode, input int wrong, input int tie_slot,
                         input int inval_slot);
        int nw;
        for (int k = 0; k < n; k++) begin
            nw = (k == tie_slot) ? 8 : (k == inval_slot) ? 5 : wrong;
            add_slot(src_d[k], mode, nw, (k == inval_slot) ? 2 : 0);
            if ((k + 1) % 8 == 0 && k + 1 != n)
                for (int i = 0; i < 16; i++) begin
                    chip_q.push_back(4'($urandom_range(15)));
                    code_q.push_back(2'($urandom_range(3)));
                end
        end
    endtask

    // Reference decode of the queued chip stream into expected writes.
    task automatic model_push(input int n, output int exp_adv, output int exp_err);
        int idx, ones1, ones0, d, nbytes, val;
        int dib[$];
        bit [3:0] c;
        idx = 0; exp_err = 0;
        for (int k = 0; k < n; k++) begin
            ones1 = 0; ones0 = 0;
            for (int i = 0; i < 16; i++) begin
                c = chip_q[idx + i];
                if (c[2] && c[0]) begin
                    d = descr(int'(code_q[idx + i]), int'({c[3], c[1]}));
                    ones1 += d / 2;
                    ones0 += d % 2;
                end else exp_err++;
            end
            idx += 16;
            dib.push_back((ones1 > 8 ? 2 : 0) + (ones0 > 8 ? 1 : 0));
            if ((k + 1) % 8 == 0 && k + 1 != n) begin
                for (int i = 0; i < 16; i++) begin
                    c = chip_q[idx + i];
                    if (!(c[2] && c[0])) exp_err++;
                end
                idx += 16;
            end
        end
        exp_adv = idx;
        nbytes = (n + 3) / 4;
        for (int j = 0; j < nbytes; j++) begin
            val = 0;
            for (int i = 0; i < 4; i++)
                if (4 * j + i < n) val += dib[4 * j + i] << (6 - 2 * i);
            exp_q.push_back('{addr: j % (1 << AW), data: val, last: (j == nbytes - 1)});
        end
        if (n == 0) exp_solo_done++;
    endtask

    // Present one chip until it is accepted, optionally with random stalls.
    task automatic send_chip(input bit [3:0] chip, input bit [1:0] code, input bit gaps);
        bit en, v;
        do begin
            en = gaps ? ($urandom_range(3) != 0) : 1'b1;
            v  = gaps ? ($urandom_range(3) != 0) : 1'b1;
            enable        = en;
            in_valid      = v;
            in_data       = v ? chip : 4'($urandom_range(15));
            scramble_code = (en && v) ? code : 2'($urandom_range(3));
            @(posedge clk); #1;
        end while (!(en && v));
    endtask

    task automatic do_start(input int n);
        start = 1'b1; msg_length = 16'(n); enable = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int n, input bit gaps);
        int ea, ee;
        model_push(n, ea, ee);
        adv_cnt = 0;
        do_start(n);
        for (int i = 0; i < chip_q.size(); i++) send_chip(chip_q[i], code_q[i], gaps);
        in_valid = 1'b0; enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("writes_pending", exp_q.size(), 0);
        check("done_pending", exp_solo_done, 0);
        check("scr_advance_count", adv_cnt, ea);
        check("chip_err_cnt", chip_err_cnt, ee);
        check("busy_after_frame", busy, 0);
        chip_q.delete(); code_q.delete(); exp_q.delete(); exp_solo_done = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ram_we"}, ram_we, 0);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_scr_advance"}, scr_advance, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_chip_err_cnt"}, chip_err_cnt, 0);
    endtask

    // Monitor: every write and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (scr_advance === 1'b1) adv_cnt++;
        if (ram_we !== 1'b0) begin
            if (exp_q.size() == 0) check("unexpected_write", ram_we, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", ram_addr, mon_e.addr);
                check("wr_data", ram_wdata, mon_e.data);
                check("done_with_last_write", done, mon_e.last);
            end
        end else if (done !== 1'b0) begin
            if (exp_solo_done > 0) exp_solo_done--;
            else check("spurious_done", done, 0);
        end
    end

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; start = 1'b0; msg_length = 16'd0;
        in_valid = 1'b0; in_data = 4'd0; scramble_code = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Clean frame: dibits 10,11,01,00 -> 0xB4.
        src_d[0] = 2; src_d[1] = 3; src_d[2] = 1; src_d[3] = 0;
        build(4, 0, 0, -1, -1);
        run_frame(4, 0);

        // Extra slot after dibit 8, codes cycling per chip.
        for (int k = 0; k < 12; k++) src_d[k] = $urandom_range(3);
        build(12, 1, 0, -1, -1);
        run_frame(12, 0);

        // Noise: 7 wrong chips per slot, a tie slot, and a slot with invalid chips.
        for (int k = 0; k < 8; k++) src_d[k] = $urandom_range(3);
        build(8, 2, 7, 3, 5);
        run_frame(8, 0);

        // Partial last byte.
        for (int k = 0; k < 5; k++) src_d[k] = 3;
        build(5, 0, 0, -1, -1);
        run_frame(5, 0);

        // Empty message.
        run_frame(0, 0);

        // Reset after 20 chips of a frame.
        src_d[0] = 1; src_d[1] = 2; src_d[2] = 3; src_d[3] = 0;
        build(4, 1, 0, -1, 0);
        do_start(4);
        for (int i = 0; i < 20; i++) send_chip(chip_q[i], code_q[i], 0);
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check_reset_values("midframe_reset");
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chip_q.delete(); code_q.delete();
        src_d[0] = 2; src_d[1] = 3; src_d[2] = 1; src_d[3] = 0;
        build(4, 0, 0, -1, -1);
        run_frame(4, 0);

        // Stalls from in_valid and enable over a 4-dibit frame.
        src_d[0] = 2; src_d[1] = 3; src_d[2] = 1; src_d[3] = 0;
        build(4, 0, 0, -1, -1);
        run_frame(4, 1);

        // Random frames.
        for (int f = 0; f < 3; f++) begin
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) src_d[k] = $urandom_range(3);
            build(n, 2, $urandom_range(0, 7), -1, $urandom_range(0, n - 1));
            run_frame(n, f[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
